matrix_mult_dot_accum: RTL and testbench
========================================

# matrix_mult_dot_accum

Dot-product accumulator sitting directly downstream of the 16x16 signed product pipeline in the no-cache matrix-multiply datapath. Consumes one 32-bit signed product per accepted beat, sums a run of `len` products into one matrix element, and presents the finished element on a valid/ready output with a sticky overflow flag. It back-pressures the product pipeline through `in_ready`, which upstream control uses as that pipeline's clock enable.

## Interface
- `PROD_WIDTH`, 32: width of the incoming signed product.
- `ACC_WIDTH`, 40: accumulator and result width; must be ≥ `PROD_WIDTH`.
- `LEN_WIDTH`, 8: width of the term-count input.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `len`  in  `LEN_WIDTH`  number of products per dot product, unsigned.
- `in_valid`  in  1  product beat present.
- `in_data`  in  `PROD_WIDTH`  signed product.
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_valid`  out  1  result held on `out_data`.
- `out_data`  out  `ACC_WIDTH`  signed dot-product result.
- `out_ovf`  out  1  signed overflow occurred in this result.
- `out_ready`  in  1  consumer takes the result.

## Operation
- Registers:
  - `acc` (`ACC_WIDTH`)
  - `cnt` (`LEN_WIDTH`)
  - `len_q` (`LEN_WIDTH`)
  - `ovf_q`
  - `busy` (run in progress)
  - output registers `out_valid`, `out_data`, `out_ovf`
- Beat accepted ⇔ `in_valid && in_ready`.
- `in_ready = !reset && (!out_valid || out_ready)`. A result completing while a previous one is still held is impossible.
- First beat of a run (`busy==0`):
  - Latch `len_q = (len==0) ? 1 : len`; `len` is ignored at all other times.
  - Set `cnt=1`, `acc = sext(in_data)`, `ovf_q=0`.
- Subsequent beats: `acc += sext(in_data)` in two's-complement `ACC_WIDTH` arithmetic (wrap, no saturation), `cnt += 1`.
- Overflow: set `ovf_q` when both addend signs match and the result sign differs.
- Completing beat (the accepted beat whose post-update count equals `len_q`, including a first beat with `len_q==1`):
  - Load `out_data` with the final sum including this beat.
  - Load `out_ovf` with `ovf_q` OR this beat's overflow.
  - Set `out_valid=1`, `busy=0`, clear `acc`/`cnt`.
- Output handshake:
  - `out_valid` stays high and `out_data`/`out_ovf` stay stable until `out_valid && out_ready`.
  - Handshake without a new completion: `out_valid` drops the next cycle.
  - Handshake coinciding with a completing beat: `out_valid` stays 1 and the new result replaces the old one with no bubble.
- `in_valid` low mid-run pauses accumulation and keeps the state unchanged.
- Reset, including mid-run or with a result held: `acc=0`, `cnt=0`, `busy=0`, `ovf_q=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`. The partial sum and any held result are discarded; `in_ready` is 0 while `reset` is high.

## Timing
- Latency: the result is visible (`out_valid=1`) on the cycle after the completing beat's clock edge.
- Throughput: one product per cycle sustained while `out_ready` is high at each completion; a dot product of length L yields one result per L cycles.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_data`/`in_valid` to any output.
- Stall: while `out_valid && !out_ready`, `in_ready=0`. Upstream must freeze the product pipeline (clock enable low) with no beats lost.
- Back-to-back runs: the first beat of the next run may be accepted on the same cycle the previous result's completing beat registers.

## Test plan
- `len=4`, products 1, 2, 3, 4 on consecutive cycles, `out_ready=1` → one cycle after the 4th beat: `out_valid=1`, `out_data=10`, `out_ovf=0`, held one cycle.
- `len=3`, products -5, 7, -1073741824 with `in_valid` gaps of 2 cycles → `out_data=-1073741822`; `acc` unchanged during gaps.
- `len=2`, 6 beats of 1 with `out_ready=0` after the first result → `out_data=2` held stable, `in_ready=0` until `out_ready` rises, then results 2, 2 follow with no beat lost.
- `ACC_WIDTH=33`, `len=4`, four products of 1073741824 → `out_data=-4294967296`, `out_ovf=1`. The next run of 1, 1 with `len=2` gives `2`, `out_ovf=0`.
- `len=0`, product 9 → single-term result 9 one cycle later. Changing `len` mid-run does not alter the run length.
- Assert `reset` for one cycle after 2 of 4 beats, then send 4 beats of 3 → no output from the aborted run; first result `12`. All outputs are 0 on the cycle after reset.

Source files
------------

// File: rtl/matrix_mult_dot_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_dot_accum_if
// Description : Product-in / result-out handshake bundle for the dot-product
//               accumulator. The master drives products and takes results;
//               the slave is the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_mult_dot_accum_if #(
    parameter int PROD_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int LEN_WIDTH  = 8
);
    // Term count for the run that starts on the next first beat
    logic        [LEN_WIDTH-1:0]  len;
    // Product stream
    logic                         in_valid;
    logic signed [PROD_WIDTH-1:0] in_data;
    logic                         in_ready;
    // Result stream
    logic                         out_valid;
    logic signed [ACC_WIDTH-1:0]  out_data;
    logic                         out_ovf;
    logic                         out_ready;

    modport master (
        output len,
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf,
        output out_ready
    );

    modport slave (
        input  len,
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/matrix_mult_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_dot_accum
// Description : Sums a run of len signed products into one matrix element and
//               presents it on a valid/ready output with a sticky overflow
//               flag. in_ready doubles as the upstream pipeline clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_dot_accum #(
    parameter int PROD_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int LEN_WIDTH  = 8
) (
    input  wire                     clk,
    input  wire                     reset,
    matrix_mult_dot_accum_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0]  acc_q,       acc_d;
    logic        [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
    logic        [LEN_WIDTH-1:0]  len_q,       len_d;
    logic                         ovf_q,       ovf_d;
    logic                         busy_q,      busy_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                         out_ovf_q,   out_ovf_d;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic                         w_in_ready;
    logic                         w_accept;
    logic signed [ACC_WIDTH-1:0]  w_addend;
    logic signed [ACC_WIDTH-1:0]  w_base;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic        [LEN_WIDTH-1:0]  w_cnt_next;
    logic        [LEN_WIDTH-1:0]  w_len_eff;
    logic                         w_beat_ovf;
    logic                         w_ovf_acc;
    logic                         w_done;

    // Accept whenever the output slot is free or is being emptied this cycle
    always_comb begin
        w_in_ready = !reset && (!out_valid_q || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Sum / count / completion for the beat presented this cycle
    always_comb begin
        // Signed cast sign-extends the product into the accumulator width
        w_addend   = ACC_WIDTH'(bus.in_data);
        // A first beat starts from zero regardless of the leftover register
        w_base     = busy_q ? acc_q : '0;
        w_sum      = w_base + w_addend;
        w_cnt_next = (busy_q ? cnt_q : '0) + LEN_WIDTH'(1);
        // len is sampled only on the first beat; zero is treated as one term
        if (busy_q) begin
            w_len_eff = len_q;
        end else if (bus.len == '0) begin
            w_len_eff = LEN_WIDTH'(1);
        end else begin
            w_len_eff = bus.len;
        end
        // Two's-complement overflow: like-signed addends, differently signed sum
        w_beat_ovf = (w_base[ACC_WIDTH-1] == w_addend[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1]  != w_base[ACC_WIDTH-1]);
        w_ovf_acc  = (busy_q && ovf_q) || w_beat_ovf;
        w_done     = (w_cnt_next == w_len_eff);
    end

    // Next-state: accumulate, complete, and output handshake
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        // Consumer took the held result
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_done) begin
                // Completion overrides the handshake drop so there is no bubble
                out_valid_d = 1'b1;
                out_data_d  = w_sum;
                out_ovf_d   = w_ovf_acc;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                busy_d      = 1'b0;
            end else begin
                acc_d  = w_sum;
                cnt_d  = w_cnt_next;
                ovf_d  = w_ovf_acc;
                busy_d = 1'b1;
                len_d  = w_len_eff;
            end
        end
    end

    // State register with synchronous reset discarding partial and held results
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_ovf   = out_ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mult_dot_accum
// Description : Directed self-checking bench for matrix_mult_dot_accum with a
//               40-bit and a 33-bit accumulator instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_dot_accum;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    matrix_mult_dot_accum_if #(.PROD_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) bus   ();
    matrix_mult_dot_accum_if #(.PROD_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) bus33 ();

    matrix_mult_dot_accum #(.PROD_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    matrix_mult_dot_accum #(.PROD_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) dut33 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; signed operands are sign-extended into 64 bits
    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic beat33(input logic signed [31:0] d);
        bus33.in_valid = 1'b1;
        bus33.in_data  = d;
        tick();
        bus33.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset           = 1'b1;
        bus.len         = 8'd0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        bus33.len       = 8'd0;
        bus33.in_valid  = 1'b0;
        bus33.in_data   = '0;
        bus33.out_ready = 1'b1;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("ready_in_reset", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_ovf",   bus.out_ovf, 0);
        check("rst_ready", bus.in_ready, 1);

        // ---------------- len=4: 1,2,3,4 ----------------
        bus.len = 8'd4;
        beat(1);
        beat(2);
        beat(3);
        check("t1_not_yet", bus.out_valid, 0);
        beat(4);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data",  bus.out_data, 10);
        check("t1_ovf",   bus.out_ovf, 0);
        tick();
        check("t1_drop", bus.out_valid, 0);

        // ---------------- len=3 with gaps ----------------
        bus.len = 8'd3;
        beat(-5);
        tick();
        tick();
        check("t2_gap1", bus.out_valid, 0);
        beat(7);
        tick();
        tick();
        check("t2_gap2", bus.out_valid, 0);
        beat(-1073741824);
        check("t2_valid", bus.out_valid, 1);
        check("t2_data",  bus.out_data, -1073741822);
        check("t2_ovf",   bus.out_ovf, 0);
        tick();

        // ---------------- len=2, 6 beats of 1, stall ----------------
        bus.len       = 8'd2;
        bus.in_valid  = 1'b1;
        bus.in_data   = 1;
        bus.out_ready = 1'b0;
        tick();                               // beat 1
        tick();                               // beat 2 completes
        check("t3_valid1", bus.out_valid, 1);
        check("t3_data1",  bus.out_data, 2);
        check("t3_stall_ready", bus.in_ready, 0);
        tick();
        tick();
        tick();
        check("t3_hold_valid", bus.out_valid, 1);
        check("t3_hold_data",  bus.out_data, 2);
        check("t3_hold_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        check("t3_release_ready", bus.in_ready, 1);
        tick();                               // beat 3 + handshake
        check("t3_drop", bus.out_valid, 0);
        tick();                               // beat 4 completes
        check("t3_valid2", bus.out_valid, 1);
        check("t3_data2",  bus.out_data, 2);
        tick();                               // beat 5 + handshake
        check("t3_drop2", bus.out_valid, 0);
        tick();                               // beat 6 completes
        bus.in_valid = 1'b0;
        check("t3_valid3", bus.out_valid, 1);
        check("t3_data3",  bus.out_data, 2);
        tick();
        check("t3_no_extra", bus.out_valid, 0);

        // ---------------- len=0 single term, then len change mid-run -------
        bus.len = 8'd0;
        beat(9);
        check("t5_valid", bus.out_valid, 1);
        check("t5_data",  bus.out_data, 9);
        tick();
        bus.len = 8'd3;
        beat(1);
        bus.len = 8'd1;
        beat(2);
        check("t5_len_ignored", bus.out_valid, 0);
        beat(3);
        check("t5_len_valid", bus.out_valid, 1);
        check("t5_len_data",  bus.out_data, 6);
        tick();

        // ---------------- len=1 back-to-back, no bubble ----------------
        bus.len      = 8'd1;
        bus.in_valid = 1'b1;
        bus.in_data  = 5;
        tick();
        check("t7_data_a", bus.out_data, 5);
        bus.in_data  = -6;
        tick();
        bus.in_valid = 1'b0;
        check("t7_valid_b", bus.out_valid, 1);
        check("t7_data_b",  bus.out_data, -6);
        tick();

        // ---------------- ACC_WIDTH=33 overflow ----------------
        bus33.len = 8'd4;
        beat33(1073741824);
        beat33(1073741824);
        beat33(1073741824);
        beat33(1073741824);
        check("t4_valid", bus33.out_valid, 1);
        check("t4_data",  bus33.out_data, -64'sd4294967296);
        check("t4_ovf",   bus33.out_ovf, 1);
        tick();
        bus33.len = 8'd2;
        beat33(1);
        beat33(1);
        check("t4b_data", bus33.out_data, 2);
        check("t4b_ovf",  bus33.out_ovf, 0);
        tick();

        // ---------------- Reset mid-run ----------------
        bus.len = 8'd4;
        beat(7);
        beat(7);
        reset = 1'b1;
        #1;
        check("t6_ready_in_reset", bus.in_ready, 0);
        tick();
        reset = 1'b0;
        check("t6_valid", bus.out_valid, 0);
        check("t6_data",  bus.out_data, 0);
        check("t6_ovf",   bus.out_ovf, 0);
        beat(3);
        beat(3);
        check("t6_no_abort_out", bus.out_valid, 0);
        beat(3);
        beat(3);
        check("t6_res_valid", bus.out_valid, 1);
        check("t6_res_data",  bus.out_data, 12);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
